bram18_fifo_ctrl: RTL and testbench

//  FIFO controller that drives one 1K x 16+2 single-port block RAM (ports ADDR/DI/DIP/EN/WE/SSR, DO/DOP).
//  The RAM has one port, so the controller arbitrates write and read on it.
//  It generates per-byte parity on write and checks it on read.

---
 rtl/bram18_pkg.sv | 20 ++
 rtl/bram18_fifo_ctrl_rd_stage.sv | 55 +++++
 rtl/bram18_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_bram18_fifo_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram18_pkg.sv
// Shared widths, RAM operation encoding and byte-parity helper for the
// single-port block RAM FIFO controller.
package bram18_pkg;
  localparam int DW = 16;
  localparam int PW = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_e;

  // One parity bit per byte; odd=1 flips each bit for odd parity.
  function automatic logic [PW-1:0] par16(input logic [DW-1:0] data, input logic odd);
    logic [PW-1:0] p;
    p = '0;
    for (int b = 0; b < PW; b++) p[b] = (^data[8*b +: 8]) ^ odd;
    return p;
  endfunction
endpackage

// File: rtl/bram18_fifo_ctrl_rd_stage.sv
// Read-return stage: tracks the in-flight RAM read, captures RAM_DO into the
// output register one cycle after the grant and checks its parity.
module bram18_rd_stage
  import bram18_pkg::*;
#(
  parameter bit PAR_ODD = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rd_grant,
  input  logic          i_m_ready,
  input  logic [DW-1:0] i_ram_do,
  input  logic [PW-1:0] i_ram_dop,
  output logic          o_rd_pend,
  output logic          o_m_valid,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_perr,
  output logic          o_perr
);
  logic          r_rd_pend;
  logic          r_m_valid;
  logic [DW-1:0] r_m_data;
  logic          r_m_perr;
  logic          r_perr;
  logic          w_bad;

  assign w_bad = (i_ram_dop != par16(i_ram_do, PAR_ODD));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_pend <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_perr  <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_rd_pend <= i_rd_grant;
      // A capture overwrites the word being consumed in the same cycle.
      if (r_rd_pend) begin
        r_m_data  <= i_ram_do;
        r_m_valid <= 1'b1;
        r_m_perr  <= w_bad;
        if (w_bad) r_perr <= 1'b1;
      end else if (r_m_valid && i_m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_rd_pend = r_rd_pend;
  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;
  assign o_m_perr  = r_m_perr;
  assign o_perr    = r_perr;
endmodule

// File: rtl/bram18_fifo_ctrl.sv
// FIFO controller for one single-port 1Kx18 block RAM: arbitrates one write or
// read per cycle, owns pointers and entry count, generates write parity.
module bram18_fifo_ctrl
  import bram18_pkg::*;
#(
  parameter int AW      = 10,
  parameter bit PAR_ODD = 1'b0,
  parameter int AF_TH   = 1000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_s_valid,
  input  logic [DW-1:0] i_s_data,
  output logic          o_s_ready,
  output logic          o_m_valid,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_perr,
  input  logic          i_m_ready,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_almost_full,
  output logic          o_perr,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_di,
  output logic [PW-1:0] o_ram_dip,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic          o_ram_ssr,
  input  logic [DW-1:0] i_ram_do,
  input  logic [PW-1:0] i_ram_dop
);
  localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_TH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          r_last_wr;
  logic          w_rd_pend;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_level;
  op_e           w_op;

  assign w_wr_ok = i_s_valid && (r_cnt < DEPTH);
  assign w_rd_ok = (r_cnt != '0) && !w_rd_pend && (!o_m_valid || i_m_ready);

  // Under contention the op that did not run last time wins.
  always_comb begin
    w_op = OP_IDLE;
    if (w_wr_ok && w_rd_ok) w_op = r_last_wr ? OP_RD : OP_WR;
    else if (w_wr_ok)       w_op = OP_WR;
    else if (w_rd_ok)       w_op = OP_RD;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_last_wr <= 1'b0;
    end else begin
      case (w_op)
        OP_WR: begin
          r_wptr    <= r_wptr + AW'(1);
          r_cnt     <= r_cnt + (AW+1)'(1);
          r_last_wr <= 1'b1;
        end
        OP_RD: begin
          r_rptr    <= r_rptr + AW'(1);
          r_cnt     <= r_cnt - (AW+1)'(1);
          r_last_wr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  bram18_rd_stage #(.PAR_ODD(PAR_ODD)) u_rd_stage (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_grant (w_op == OP_RD),
    .i_m_ready  (i_m_ready),
    .i_ram_do   (i_ram_do),
    .i_ram_dop  (i_ram_dop),
    .o_rd_pend  (w_rd_pend),
    .o_m_valid  (o_m_valid),
    .o_m_data   (o_m_data),
    .o_m_perr   (o_m_perr),
    .o_perr     (o_perr)
  );

  assign w_level       = r_cnt + (AW+1)'(w_rd_pend) + (AW+1)'(o_m_valid);
  assign o_level       = w_level;
  assign o_full        = (r_cnt == DEPTH);
  assign o_almost_full = (w_level >= AF_LVL);
  assign o_s_ready     = !o_full && !(w_rd_ok && r_last_wr);

  assign o_ram_en   = (w_op != OP_IDLE) && !i_rst;
  assign o_ram_we   = (w_op == OP_WR) && !i_rst;
  assign o_ram_addr = (w_op == OP_RD) ? r_rptr : r_wptr;
  assign o_ram_di   = i_s_data;
  assign o_ram_dip  = par16(i_s_data, PAR_ODD);
  assign o_ram_ssr  = 1'b0;
endmodule

// File: tb/tb_bram18_fifo_ctrl.sv
// Randomized bench for bram18_fifo_ctrl with a behavioural RAM and a
// queue-based scoreboard of accepted-but-unconsumed words.
module tb_bram18_fifo_ctrl;
  localparam int AW      = 10;
  localparam int DEPTH   = 1 << AW;
  localparam bit PAR_ODD = 1'b0;
  localparam int AF_TH   = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [15:0]   s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [15:0]   m_data;
  logic          m_perr;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic          full, almost_full, perr;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_di;
  logic [1:0]    ram_dip;
  logic          ram_en, ram_we, ram_ssr;
  logic [15:0]   ram_do = '0;
  logic [1:0]    ram_dop = '0;

  bram18_fifo_ctrl #(.AW(AW), .PAR_ODD(PAR_ODD), .AF_TH(AF_TH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_perr(m_perr), .i_m_ready(m_ready),
    .o_level(level), .o_full(full), .o_almost_full(almost_full), .o_perr(perr),
    .o_ram_addr(ram_addr), .o_ram_di(ram_di), .o_ram_dip(ram_dip),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_ssr(ram_ssr),
    .i_ram_do(ram_do), .i_ram_dop(ram_dop)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // behavioural RAM; flip_en corrupts DOP[0] on reads of address 5
  logic [17:0] mem [DEPTH];
  logic        flip_en = 1'b0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= {ram_dip, ram_di};
      else begin
        ram_do  <= mem[ram_addr][15:0];
        ram_dop <= mem[ram_addr][17:16] ^ ((flip_en && ram_addr == 5) ? 2'b01 : 2'b00);
      end
    end
  end

  // scoreboard
  int          n_chk = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  int          lat_q[$];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [1:0]  last_dip = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_par(input logic [15:0] d);
    logic [1:0] p;
    for (int b = 0; b < 2; b++) p[b] = ((($countones(d[8*b +: 8]) + int'(PAR_ODD)) % 2) == 1);
    return p;
  endfunction

  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete(); lat_q.delete();
      wr_cnt = 0; rd_cnt = 0;
    end else begin
      check_eq("level", level, exp_q.size());
      check_eq("almost_full", almost_full, exp_q.size() >= AF_TH);
      if (exp_q.size() < DEPTH) check_eq("full_low", full, 0);
      check_eq("ssr", ram_ssr, 0);
      if (lat_q.size() != 0 && lat_q[0] == cyc - 2) begin
        check_eq("rd_latency", m_valid, 1);
        void'(lat_q.pop_front());
      end
      if (ram_en && !ram_we) begin
        check_eq("rd_addr", ram_addr, rd_cnt % DEPTH);
        rd_cnt++;
        lat_q.push_back(cyc);
      end
      if (s_valid && s_ready) begin
        check_eq("wr_en", {ram_en, ram_we}, 2'b11);
        check_eq("wr_addr", ram_addr, wr_cnt % DEPTH);
        check_eq("wr_di", ram_di, s_data);
        check_eq("wr_dip", ram_dip, ref_par(s_data));
        last_dip = ram_dip;
        exp_q.push_back({flip_en && (wr_cnt % DEPTH == 5), s_data});
        wr_cnt++;
      end else begin
        check_eq("no_wr", ram_we, 0);
      end
      if (m_valid && m_ready) begin
        check_eq("out_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("m_data", m_data, e[15:0]);
          check_eq("m_perr", m_perr, e[16]);
        end
      end
    end
  end

  // driver tasks
  task automatic wr(input logic [15:0] d);
    s_valid = 1'b1; s_data = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    check_eq("wr_accept", s_ready, 1);
    @(posedge clk); #1 s_valid = 1'b0;
  endtask

  task automatic drain();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 5000 && exp_q.size() != 0; k++) @(posedge clk);
    check_eq("drain_done", exp_q.size(), 0);
    #1 m_ready = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic prev_we;
    // 1: reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_perr", perr, 0);

    // 2: three words, then drain in order
    @(posedge clk); #1;
    wr(16'h1234);
    check_eq("dip_1234", last_dip, 2'b01);
    wr(16'hABCD);
    wr(16'h00FF);
    @(negedge clk);
    check_eq("level_3", level, 3);
    drain();

    // 3: fill to full, partial drain, refill across the pointer wrap
    do_reset();
    s_valid = 1'b1;
    for (int k = 0; k < 1300 && exp_q.size() < DEPTH + 1; k++) begin
      s_data = 16'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("full_level", level, DEPTH + 1);
    check_eq("full_flag", full, 1);
    check_eq("full_s_ready", s_ready, 0);
    check_eq("full_af", almost_full, 1);
    @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() > DEPTH + 1 - 10; k++) @(posedge clk);
    #1 m_ready = 1'b0;
    for (int k = 0; k < 10; k++) wr(16'($urandom));
    drain();

    // 4: saturated traffic alternates write and read grants
    do_reset();
    for (int k = 0; k < 4; k++) wr(16'($urandom));
    s_valid = 1'b1; m_ready = 1'b1;
    prev_we = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k > 6) begin
        check_eq("alt_en", ram_en, 1);
        check_eq("alt_toggle", ram_we, !prev_we);
      end
      prev_we = ram_we;
      @(posedge clk); #1 s_data = 16'($urandom);
    end
    drain();
    check_eq("perr_clean", perr, 0);

    // random traffic
    rand_cycles(2000);
    drain();

    // 5: corrupted parity at address 5
    do_reset();
    flip_en = 1'b1;
    for (int k = 0; k < 8; k++) wr(16'($urandom));
    drain();
    check_eq("perr_sticky", perr, 1);
    rand_cycles(50);
    drain();
    check_eq("perr_hold", perr, 1);
    do_reset();
    flip_en = 1'b0;
    @(negedge clk);
    check_eq("perr_cleared", perr, 0);

    // 6: reset while a read is in flight
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) wr(16'($urandom));
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_en && !ram_we) break;
    end
    check_eq("rd_seen", ram_en && !ram_we, 1);
    @(posedge clk); #1;
    s_valid = 1'b1; rst = 1'b1;
    #1;
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_ram_we", ram_we, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check_eq("post_rst_m_valid", m_valid, 0);
    check_eq("post_rst_level", level, 0);
    repeat (3) @(negedge clk);
    check_eq("post_rst_m_valid2", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
